// File: rtl/divider_pkg.sv
// Shared types and constants for the ref_clk-domain divider controller.
package divider_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        MEASURE = 3'd2,
        LOAD    = 3'd3,
        RUN     = 3'd4,
        FAULT   = 3'd5
    } state_e;

    typedef logic [1:0] fault_t;

    localparam fault_t FAULT_NONE    = 2'b00;
    localparam fault_t FAULT_TIMEOUT = 2'b01;
    localparam fault_t FAULT_KSMALL  = 2'b10;

    // Terminal count of the datapath reload counter.
    localparam logic [7:0] CNT_MAX = 8'd255;

    // A reload value of CNT_MAX-(k>>1) equal to CNT_MAX means the counter would
    // sit on its terminal count and never produce a period.
    function automatic logic k_too_small(input logic [7:0] k);
        return (CNT_MAX - (k >> 1)) == CNT_MAX;
    endfunction

endpackage

// File: rtl/watchdog_timer.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags when
// the count has reached TIMEOUT_CYCLES.
module watchdog_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: held at zero when cleared or disabled, saturating at LIMIT.
    always_comb begin
        count_d = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + 16'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LIMIT);

endmodule

// File: rtl/divider_controller.sv
// Sequencing FSM for the frequency-divider datapath: arms a measurement,
// waits for k, then loads and free-runs the reload counter with fault checks.
module divider_controller
    import divider_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        ref_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [2:0]  n_in,
    input  logic        kcalc,
    input  logic [7:0]  k,
    input  logic        cout,
    output logic        LdCnt,
    output logic        counten,
    output logic [2:0]  n,
    output logic        busy,
    output logic        locked,
    output logic [1:0]  fault_code,
    output logic [15:0] pulse_count
);

    state_e      state_q, state_d;
    logic        kcalc_q, kcalc_d;
    logic [2:0]  n_q, n_d;
    fault_t      fault_code_q, fault_code_d;
    logic [15:0] pulse_count_q, pulse_count_d;

    logic kcalc_rise;
    logic kcalc_change;
    logic k_small;
    logic start_accept;
    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    assign kcalc_rise   = kcalc & ~kcalc_q;
    assign kcalc_change = kcalc ^ kcalc_q;
    assign k_small      = k_too_small(k);
    assign start_accept = start && !stop && ((state_q == IDLE) || (state_q == FAULT));

    assign wd_enable = (state_q == ARM) || (state_q == MEASURE) || (state_q == RUN);
    assign wd_clear  = kcalc_change || (state_d != state_q);

    watchdog_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (ref_clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // State register.
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and fault code: stop, then faults (k-small over timeout), then normal flow.
    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        if (stop) begin
            state_d      = IDLE;
            fault_code_d = FAULT_NONE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d      = ARM;
                        fault_code_d = FAULT_NONE;
                    end
                end
                ARM: begin
                    if (wd_expired) begin
                        state_d      = FAULT;
                        fault_code_d = FAULT_TIMEOUT;
                    end else if (!kcalc) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (wd_expired) begin
                        state_d      = FAULT;
                        fault_code_d = FAULT_TIMEOUT;
                    end else if (kcalc_rise) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (k_small) begin
                        state_d      = FAULT;
                        fault_code_d = FAULT_KSMALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (cout && k_small) begin
                        state_d      = FAULT;
                        fault_code_d = FAULT_KSMALL;
                    end else if (wd_expired) begin
                        state_d      = FAULT;
                        fault_code_d = FAULT_TIMEOUT;
                    end
                end
                FAULT: begin
                    if (start) begin
                        state_d      = ARM;
                        fault_code_d = FAULT_NONE;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    fault_code_d = FAULT_NONE;
                end
            endcase
        end
    end

    // Control outputs; RUN is Mealy on cout so every terminal count reloads in place.
    always_comb begin
        LdCnt   = 1'b0;
        counten = 1'b0;
        busy    = 1'b0;
        locked  = 1'b0;
        unique case (state_q)
            ARM, MEASURE: begin
                busy = 1'b1;
            end
            LOAD: begin
                LdCnt = 1'b1;
                busy  = 1'b1;
            end
            RUN: begin
                LdCnt   = cout;
                counten = ~cout;
                busy    = 1'b1;
                locked  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Edge-detector history, latched exponent and saturating reload count.
    always_comb begin
        kcalc_d       = kcalc;
        n_d           = n_q;
        pulse_count_d = pulse_count_q;
        if (start_accept) begin
            n_d           = n_in;
            pulse_count_d = '0;
        end else if ((state_q == RUN) && cout && (pulse_count_q != '1)) begin
            pulse_count_d = pulse_count_q + 16'd1;
        end
    end

    // Bookkeeping registers.
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            kcalc_q       <= 1'b0;
            n_q           <= '0;
            fault_code_q  <= FAULT_NONE;
            pulse_count_q <= '0;
        end else begin
            kcalc_q       <= kcalc_d;
            n_q           <= n_d;
            fault_code_q  <= fault_code_d;
            pulse_count_q <= pulse_count_d;
        end
    end

    assign n           = n_q;
    assign fault_code  = fault_code_q;
    assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_divider_controller.sv
// Self-checking bench for divider_controller with a stub reload counter.
`timescale 1ns/1ps
module tb_divider_controller;

    localparam int unsigned TO = 16;

    logic        ref_clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [2:0]  n_in;
    logic        kcalc;
    logic [7:0]  k;
    logic        cout;
    logic        LdCnt;
    logic        counten;
    logic [2:0]  n;
    logic        busy;
    logic        locked;
    logic [1:0]  fault_code;
    logic [15:0] pulse_count;

    int total = 0;
    int bad   = 0;

    // Reference model state: cycles until the next terminal count, expected
    // reload count and the exponent that should be latched.
    int         rem;
    int         model_pc;
    logic [2:0] exp_n;
    logic [7:0] kv;

    // Stub datapath counter: loads 255-(k>>1), counts up, terminal at 255.
    logic [7:0] cnt;

    divider_controller #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ref_clk     (ref_clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .n_in        (n_in),
        .kcalc       (kcalc),
        .k           (k),
        .cout        (cout),
        .LdCnt       (LdCnt),
        .counten     (counten),
        .n           (n),
        .busy        (busy),
        .locked      (locked),
        .fault_code  (fault_code),
        .pulse_count (pulse_count)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    always_ff @(posedge ref_clk) begin
        if (rst)          cnt <= 8'd0;
        else if (LdCnt)   cnt <= 8'd255 - (k >> 1);
        else if (counten) cnt <= cnt + 8'd1;
    end
    assign cout = (cnt == 8'd255);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_LdCnt"}, LdCnt, 0);
        chk({tag, "_counten"}, counten, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_locked"}, locked, 0);
    endtask

    // Start from IDLE/FAULT, pass through ARM and MEASURE, end in the LOAD cycle.
    task automatic goto_run(input logic [7:0] kval, input logic [2:0] nv);
        kcalc = 1'b0;
        n_in  = nv;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("arm_busy", busy, 1);
        chk("arm_n", n, nv);
        chk("arm_fault", fault_code, 0);
        chk("arm_pulse", pulse_count, 0);
        tick();
        chk("meas_busy", busy, 1);
        chk("meas_LdCnt", LdCnt, 0);
        kcalc = 1'b1;
        k     = kval;
        tick();
        chk("load_LdCnt", LdCnt, 1);
        chk("load_counten", counten, 0);
        chk("load_locked", locked, 0);
        exp_n    = nv;
        rem      = int'(kval >> 1) + 1;
        model_pc = 0;
    endtask

    // One RUN cycle: reloads every (k>>1)+1 cycles, k taken at each reload.
    task automatic run_step(input bit toggle, input logic [7:0] knew);
        logic exp_c;
        tick();
        k = knew;
        if (toggle) kcalc = ~kcalc;
        n_in = 3'($urandom);
        rem--;
        exp_c = (rem == 0);
        chk("cout", cout, exp_c);
        chk("run_LdCnt", LdCnt, exp_c);
        chk("run_counten", counten, !exp_c);
        chk("run_locked", locked, 1);
        chk("n_held", n, exp_n);
        chk("pulse_count", pulse_count, model_pc);
        if (exp_c) begin
            rem = int'(knew >> 1) + 1;
            if (model_pc < 65535) model_pc++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        kcalc = 1'b0;
        k     = 8'd10;
        n_in  = 3'd0;
        exp_n = 3'd0;
        repeat (3) tick();
        chk_all_zero("reset");
        chk("reset_n", n, 0);
        chk("reset_fault", fault_code, 0);
        chk("reset_pulse", pulse_count, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // k=10: reload every 6 cycles, four reloads then count of 4.
        goto_run(8'd10, 3'd3);
        for (int i = 1; i <= 25; i++) run_step((i % 4) == 0, 8'd10);
        chk("pulse_after_4", pulse_count, 4);

        // stop mid-RUN.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all_zero("stop_run");
        chk("stop_fault", fault_code, 0);

        // Random k, changed at random points; new k applies from the next reload.
        for (int r = 0; r < 4; r++) begin
            kv = 8'($urandom_range(255, 2));
            goto_run(kv, 3'($urandom));
            for (int i = 1; i <= 300; i++) begin
                if ($urandom_range(7, 0) == 0) kv = 8'($urandom_range(255, 2));
                run_step((i % 3) == 0, kv);
            end
            stop = 1'b1;
            tick();
            stop = 1'b0;
            chk_all_zero("stop_rand");
        end

        // k too small at a RUN reload.
        goto_run(8'd8, 3'd5);
        for (int i = 1; i <= 4; i++) run_step(1'b1, 8'd8);
        run_step(1'b1, 8'd1);
        tick();
        chk("ksmall_run_fault", fault_code, 2);
        chk_all_zero("ksmall_run");
        chk("ksmall_run_pulse", pulse_count, 1);
        tick();
        chk("ksmall_sticky", fault_code, 2);

        // k too small at LOAD, then start clears the fault.
        goto_run(8'd1, 3'd2);
        tick();
        chk("ksmall_load_fault", fault_code, 2);
        chk_all_zero("ksmall_load");

        // Watchdog: restarts from 0 the cycle after the last change is seen,
        // reaches TO sixteen cycles later, FAULT one cycle after that.
        goto_run(8'd6, 3'd1);
        for (int i = 1; i <= 10; i++) run_step(1'b1, 8'd6);
        for (int m = 1; m <= 20; m++) begin
            tick();
            chk("timeout_fault", fault_code, (m >= int'(TO) + 2) ? 1 : 0);
            chk("timeout_busy", busy, (m >= int'(TO) + 2) ? 0 : 1);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("timeout_stop_fault", fault_code, 0);
        chk_all_zero("timeout_stop");

        // start together with stop in IDLE: nothing latched, stays IDLE.
        start = 1'b1;
        stop  = 1'b1;
        n_in  = ~exp_n;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", busy, 0);
        chk("startstop_n", n, exp_n);
        tick();
        chk("startstop_busy2", busy, 0);

        // rst mid-RUN.
        goto_run(8'd20, 3'd7);
        for (int i = 1; i <= 5; i++) run_step(1'b1, 8'd20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rst_run");
        chk("rst_run_n", n, 0);
        chk("rst_run_fault", fault_code, 0);
        chk("rst_run_pulse", pulse_count, 0);

        // Saturation: reload count preset just below 16'hFFFF, k=2.
        goto_run(8'd2, 3'd4);
        force dut.pulse_count_q = 16'hFFFB;
        model_pc = 32'hFFFB;
        run_step(1'b0, 8'd2);
        release dut.pulse_count_q;
        for (int i = 2; i <= 20; i++) run_step((i % 2) == 0, 8'd2);
        chk("pulse_saturated", pulse_count, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
